// File: rtl/gelato_l1_inst_cache_dm.sv
// Direct-mapped L1 instruction cache: flop-based tag/data storage, multi-beat
// refill FSM, global flush and saturating hit/miss counters.
module gelato_l1_inst_cache_dm #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32,
   parameter int LINE_WORDS = 4,
   parameter int LINE_NUM   = 64,
   parameter int CNT_WIDTH  = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  rdy,
   input  logic                  flush,
   input  logic                  req_valid,
   input  logic [ADDR_WIDTH-1:0] req_addr,
   output logic                  req_done,
   output logic [DATA_WIDTH-1:0] req_data,
   output logic                  ram_valid,
   output logic [ADDR_WIDTH-1:0] ram_addr,
   input  logic                  ram_done,
   input  logic [DATA_WIDTH-1:0] ram_data,
   output logic [CNT_WIDTH-1:0]  hit_count,
   output logic [CNT_WIDTH-1:0]  miss_count
);

   localparam int OFF_W   = $clog2(LINE_WORDS);
   localparam int IDX_W   = $clog2(LINE_NUM);
   localparam int TAG_LSB = OFF_W + IDX_W + 2;
   localparam int TAG_W   = ADDR_WIDTH - TAG_LSB;
   localparam logic [OFF_W-1:0] LAST_BEAT = OFF_W'(LINE_WORDS - 1);

   typedef enum logic [1:0] {IDLE, REFILL, RESP} state_t;

   state_t                  state_reg;
   logic [OFF_W-1:0]        beat_reg;
   logic [OFF_W-1:0]        off_reg;
   logic [IDX_W-1:0]        fill_idx_reg;
   logic [TAG_W-1:0]        fill_tag_reg;
   logic                    flush_pend_reg;
   logic                    req_done_reg;
   logic [DATA_WIDTH-1:0]   req_data_reg;
   logic                    ram_valid_reg;
   logic [ADDR_WIDTH-1:0]   ram_addr_reg;
   logic [CNT_WIDTH-1:0]    hit_count_reg;
   logic [CNT_WIDTH-1:0]    miss_count_reg;

   logic [TAG_W-1:0]        tag_mem  [LINE_NUM];
   logic [DATA_WIDTH-1:0]   data_mem [LINE_NUM][LINE_WORDS];
   logic [LINE_NUM-1:0]     valid_bits;

   logic [OFF_W-1:0]        req_off;
   logic [IDX_W-1:0]        req_idx;
   logic [TAG_W-1:0]        req_tag;
   logic                    hit;
   logic [DATA_WIDTH-1:0]   hit_word;
   logic                    beat_accept;
   logic                    last_accept;
   logic                    inv_all;
   logic                    set_valid;
   logic                    unused_addr_bits;

   assign req_off  = req_addr[OFF_W+1:2];
   assign req_idx  = req_addr[TAG_LSB-1:OFF_W+2];
   assign req_tag  = req_addr[ADDR_WIDTH-1:TAG_LSB];
   assign hit      = valid_bits[req_idx] && (tag_mem[req_idx] == req_tag);
   assign hit_word = data_mem[req_idx][req_off];
   assign unused_addr_bits = ^req_addr[1:0];

   assign beat_accept = rdy && (state_reg == REFILL) && ram_done;
   assign last_accept = beat_accept && (beat_reg == LAST_BEAT);
   assign inv_all     = rdy && flush;
   // A flush seen earlier in this refill keeps the finished line invalid.
   assign set_valid   = last_accept && !flush_pend_reg;

   generate
      for (genvar gi = 0; gi < LINE_NUM; gi++) begin : g_valid
         logic v_reg;
         always_ff @(posedge clk or posedge rst) begin
            if (rst)
               v_reg <= 1'b0;
            else if (inv_all)
               v_reg <= 1'b0;
            else if (set_valid && (fill_idx_reg == IDX_W'(gi)))
               v_reg <= 1'b1;
         end
         assign valid_bits[gi] = v_reg;
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (beat_accept) begin
         data_mem[fill_idx_reg][beat_reg] <= ram_data;
         if (beat_reg == LAST_BEAT)
            tag_mem[fill_idx_reg] <= fill_tag_reg;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg      <= IDLE;
         beat_reg       <= '0;
         off_reg        <= '0;
         fill_idx_reg   <= '0;
         fill_tag_reg   <= '0;
         flush_pend_reg <= 1'b0;
         req_done_reg   <= 1'b0;
         req_data_reg   <= '0;
         ram_valid_reg  <= 1'b0;
         ram_addr_reg   <= '0;
         hit_count_reg  <= '0;
         miss_count_reg <= '0;
      end else if (rdy) begin
         req_done_reg <= 1'b0;
         if (flush && (state_reg == REFILL))
            flush_pend_reg <= 1'b1;
         case (state_reg)
            IDLE: begin
               if (req_valid) begin
                  if (hit) begin
                     req_data_reg <= hit_word;
                     req_done_reg <= 1'b1;
                     if (~&hit_count_reg)
                        hit_count_reg <= hit_count_reg + CNT_WIDTH'(1);
                     state_reg <= RESP;
                  end else begin
                     if (~&miss_count_reg)
                        miss_count_reg <= miss_count_reg + CNT_WIDTH'(1);
                     beat_reg      <= '0;
                     off_reg       <= req_off;
                     fill_idx_reg  <= req_idx;
                     fill_tag_reg  <= req_tag;
                     ram_valid_reg <= 1'b1;
                     ram_addr_reg  <= {req_addr[ADDR_WIDTH-1:OFF_W+2], (OFF_W+2)'(0)};
                     state_reg     <= REFILL;
                  end
               end
            end
            REFILL: begin
               if (ram_done) begin
                  if (beat_reg == off_reg)
                     req_data_reg <= ram_data;
                  if (beat_reg == LAST_BEAT) begin
                     ram_valid_reg  <= 1'b0;
                     req_done_reg   <= 1'b1;
                     flush_pend_reg <= 1'b0;
                     state_reg      <= RESP;
                  end else begin
                     beat_reg     <= beat_reg + OFF_W'(1);
                     ram_addr_reg <= ram_addr_reg + ADDR_WIDTH'(4);
                  end
               end
            end
            RESP: begin
               state_reg <= IDLE;
            end
            default: begin
               state_reg <= IDLE;
            end
         endcase
      end
   end

   assign req_done   = req_done_reg;
   assign req_data   = req_data_reg;
   assign ram_valid  = ram_valid_reg;
   assign ram_addr   = ram_addr_reg;
   assign hit_count  = hit_count_reg;
   assign miss_count = miss_count_reg;

endmodule
